// File: rtl/lif_neuron_pkg.sv
// Shared constants and datapath helpers for the LIF neuron.
// The setting bus layout and the membrane arithmetic are defined here.
package lif_neuron_pkg;

   localparam int V_W = 8;
   localparam int R_W = 4;

   localparam int SHIFT_MSB = 7;
   localparam int SHIFT_LSB = 5;
   localparam int THR_MSB   = 4;
   localparam int THR_LSB   = 1;

   localparam int SHIFT_W = SHIFT_MSB - SHIFT_LSB + 1;
   localparam int THR_W   = THR_MSB - THR_LSB + 1;

   localparam logic [3:0]     THR_LOW_NIBBLE = 4'hF;
   localparam logic [V_W-1:0] UIO_OE_MASK    = 8'h01;

   // A shift of zero disables the leak entirely.
   function automatic logic [V_W-1:0] leak_fn(input logic [V_W-1:0] v,
                                              input logic [SHIFT_W-1:0] s);
      logic [V_W-1:0] l;
      l = v;
      if (s != '0) begin
         l = v - (v >> s);
      end
      return l;
   endfunction

   function automatic logic [V_W-1:0] sat_add_fn(input logic [V_W-1:0] a,
                                                 input logic [V_W-1:0] b);
      logic [V_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[V_W] ? {V_W{1'b1}} : sum[V_W-1:0];
   endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// Leak/integrate/fire datapath with membrane, spike and refractory registers.
// A spike clears the membrane and arms the refractory counter.
module lif_neuron_core
   import lif_neuron_pkg::*;
#(
   parameter int REFRACTORY_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic [V_W-1:0]     current,
   input  logic [SHIFT_W-1:0] shift,
   input  logic [V_W-1:0]     thr,
   output logic [V_W-1:0]     v,
   output logic               spike
);

   localparam logic [R_W-1:0] R_LOAD = R_W'(REFRACTORY_CYCLES);

   logic [R_W-1:0] r_cnt;
   logic [V_W-1:0] leaked;
   logic [V_W-1:0] p_sat;
   logic           refractory;
   logic           fire;

   always_comb begin
      leaked     = leak_fn(v, shift);
      p_sat      = sat_add_fn(leaked, current);
      refractory = (r_cnt != '0);
      fire       = (p_sat >= thr);
   end

   // Reset outranks enable; ena low freezes every register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v     <= '0;
         spike <= 1'b0;
         r_cnt <= '0;
      end else if (ena) begin
         if (refractory) begin
            v     <= '0;
            spike <= 1'b0;
            r_cnt <= r_cnt - 1'b1;
         end else if (fire) begin
            v     <= '0;
            spike <= 1'b1;
            r_cnt <= R_LOAD;
         end else begin
            v     <= p_sat;
            spike <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/lif_neuron.sv
// Tiny Tapeout pin wrapper: decodes the setting bus and packs outputs.
// uio[0] is the only driven bidirectional pin and carries the spike.
module lif_neuron
   import lif_neuron_pkg::*;
#(
   parameter int REFRACTORY_CYCLES = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ena,
   input  logic [V_W-1:0] ui_in,
   input  logic [V_W-1:0] uio_in,
   output logic [V_W-1:0] uo_out,
   output logic [V_W-1:0] uio_out,
   output logic [V_W-1:0] uio_oe
);

   logic [SHIFT_W-1:0] shift;
   logic [V_W-1:0]     thr;
   logic               spike;
   logic               unused_uio0;

   // Low nibble forced high keeps the threshold within 15..255.
   assign shift       = uio_in[SHIFT_MSB:SHIFT_LSB];
   assign thr         = {uio_in[THR_MSB:THR_LSB], THR_LOW_NIBBLE};
   assign unused_uio0 = uio_in[0];

   lif_neuron_core #(
      .REFRACTORY_CYCLES(REFRACTORY_CYCLES)
   ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .current(ui_in),
      .shift  (shift),
      .thr    (thr),
      .v      (uo_out),
      .spike  (spike)
   );

   assign uio_out = {{(V_W-1){1'b0}}, spike};
   assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed-vector bench for lif_neuron, plus a zero-refractory instance
// used for the back-to-back firing sequence.
module tb_lif_neuron;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out,  uio_out,  uio_oe;
   logic [7:0] uo_out0, uio_out0, uio_oe0;

   int n_vec;
   int n_err;

   logic [23:0] exp_q[$];

   typedef struct packed {
      logic       rst_n;
      logic       ena;
      logic [7:0] ui;
      logic [7:0] uio;
      logic [7:0] exp_v;
      logic       exp_spk;
   } vec_t;

   vec_t vecs[$];

   lif_neuron #(.REFRACTORY_CYCLES(2)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   lif_neuron #(.REFRACTORY_CYCLES(0)) dut0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out0),
      .uio_out(uio_out0),
      .uio_oe (uio_oe0)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] pack_exp(input logic [7:0] v, input logic spk);
      return {v, 7'b0, spk, 8'h01};
   endfunction

   task automatic drive(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] uio);
      rst_n  = r;
      ena    = e;
      ui_in  = ui;
      uio_in = uio;
   endtask

   task automatic check(input string name, input logic [23:0] act);
      logic [23:0] exp;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: expected queue empty, got %h", name, act);
      end else begin
         exp = exp_q.pop_front();
         n_vec++;
         if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got uo=%0d uio_out=%h oe=%h, need uo=%0d uio_out=%h oe=%h",
                     name, act[23:16], act[15:8], act[7:0], exp[23:16], exp[15:8], exp[7:0]);
         end
      end
   endtask

   // Drive, clock once, compare main DUT.
   task automatic step(input string name, input logic r, input logic e, input logic [7:0] ui,
                       input logic [7:0] uio, input logic [7:0] ev, input logic es);
      drive(r, e, ui, uio);
      exp_q.push_back(pack_exp(ev, es));
      @(posedge clk);
      #1;
      check(name, {uo_out, uio_out, uio_oe});
   endtask

   task automatic add(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] uio,
                      input logic [7:0] ev, input logic es);
      vec_t t;
      t.rst_n = r; t.ena = e; t.ui = ui; t.uio = uio; t.exp_v = ev; t.exp_spk = es;
      vecs.push_back(t);
   endtask

   initial begin
      logic [7:0] sub_seq[9];
      logic [7:0] sv;
      n_vec = 0;
      n_err = 0;
      drive(1'b0, 1'b1, 8'd255, 8'h38);

      // reset, then fire with leak (S=1, T=207)
      add(0, 1, 255, 8'h38,   0, 0);
      add(0, 1, 255, 8'h38,   0, 0);
      add(1, 1, 120, 8'h38, 120, 0);
      add(1, 1, 120, 8'h38, 180, 0);
      add(1, 1, 120, 8'h38,   0, 1);
      add(1, 1, 120, 8'h38,   0, 0);
      add(1, 1, 120, 8'h38,   0, 0);
      add(1, 1, 120, 8'h38, 120, 0);
      add(1, 1, 120, 8'h38, 180, 0);
      add(1, 1, 120, 8'h38,   0, 1);
      // reset during refractory clears R
      add(0, 1, 120, 8'h38,   0, 0);
      add(1, 1, 120, 8'h38, 120, 0);
      // saturation with max threshold (S=0, T=255)
      add(0, 1,   0, 8'h1E,   0, 0);
      add(1, 1, 200, 8'h1E, 200, 0);
      add(1, 1, 200, 8'h1E,   0, 1);
      add(1, 1, 200, 8'h1E,   0, 0);
      add(1, 1, 200, 8'h1E,   0, 0);
      add(1, 1, 200, 8'h1E, 200, 0);
      // ena gating mid-integration, then fire on re-enable
      add(0, 1,   0, 8'h38,   0, 0);
      add(1, 1, 120, 8'h38, 120, 0);
      add(1, 1, 120, 8'h38, 180, 0);
      for (int k = 0; k < 5; k++) add(1, 0, 120, 8'h38, 180, 0);
      add(1, 1, 120, 8'h38,   0, 1);
      // ena low holds the spike and the refractory count
      add(1, 0, 120, 8'h38,   0, 1);
      add(1, 0, 120, 8'h38,   0, 1);
      add(1, 1, 120, 8'h38,   0, 0);
      add(1, 1, 120, 8'h38,   0, 0);
      add(1, 1, 120, 8'h38, 120, 0);
      // threshold boundary at T=15, S=0: P==T fires, P==T-1 holds
      add(0, 1,   0, 8'h00,   0, 0);
      add(1, 1,  15, 8'h00,   0, 1);
      add(0, 1,   0, 8'h00,   0, 0);
      add(1, 1,  14, 8'h00,  14, 0);
      add(1, 1,   0, 8'h00,  14, 0);
      add(1, 1,   1, 8'h00,   0, 1);
      // S=7 leak, T=255: 200 -> 200-1+200 saturates and fires
      add(0, 1,   0, 8'hFE,   0, 0);
      add(1, 1, 200, 8'hFE, 200, 0);
      add(1, 1, 200, 8'hFE,   0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].ena, vecs[i].ui, vecs[i].uio,
              vecs[i].exp_v, vecs[i].exp_spk);
      end

      // sub-threshold convergence: settles at 200 < 207, never spikes
      sub_seq = '{100, 150, 175, 188, 194, 197, 199, 200, 200};
      step("sub_rst", 0, 1, 0, 8'h38, 0, 0);
      for (int c = 0; c < 50; c++) begin
         sv = (c < 9) ? sub_seq[c] : 8'd200;
         step($sformatf("sub%0d", c), 1, 1, 100, 8'h38, sv, 0);
      end

      // back-to-back firing only with zero refractory
      step("b2b_rst", 0, 1, 0, 8'h1E, 0, 0);
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 1'b1, 8'd255, 8'h1E);
         exp_q.push_back(pack_exp(8'd0, (c == 0)));
         exp_q.push_back(pack_exp(8'd0, 1'b1));
         @(posedge clk);
         #1;
         check($sformatf("b2b_main%0d", c), {uo_out, uio_out, uio_oe});
         check($sformatf("b2b_zero%0d", c), {uo_out0, uio_out0, uio_oe0});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog so the bench cannot hang.
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, need finish");
      $fatal(1, "timeout");
   end

endmodule
